bsg_global_buffer_bank_arbiter: RTL and testbench
=================================================

# bsg_global_buffer_bank_arbiter

Per-tile bank port controller for the global buffer. It shares one single-ported (1RW) SRAM bank between three requesters: the read-only (ro) streaming network, the write-only (wo) streaming network, and the rw mesh endpoint. It applies a fixed-priority-plus-anti-starvation policy, buffers wo writes, and steers the one-cycle-latency read data back to the requester that issued the read. One instance sits inside each `bsg_global_buffer_tile`, between the network endpoints and the bank SRAM.

## Interface

**Parameters**
- `data_width_p`, 32: word width.
- `bank_els_p`, 1024: bank depth. `bank_addr_width_lp = BSG_SAFE_CLOG2(bank_els_p)`.
- `wo_fifo_els_p`, 2: wo buffer depth, ≥1.
- `starve_limit_p`, 4: consecutive denied rw cycles before rw is promoted, ≥1.

**Ports**
- `clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: reset, synchronous and active-low.
- `ro_v_i`, in, 1: ro read request. It cannot be stalled.
- `ro_addr_i`, in, `bank_addr_width_lp`: ro read address.
- `ro_data_o`, out, `data_width_p`: ro read data.
- `ro_v_o`, out, 1: `ro_data_o` valid.
- `wo_v_i`, in, 1: wo write valid.
- `wo_addr_i`, in, `bank_addr_width_lp`: wo write address.
- `wo_data_i`, in, `data_width_p`: wo write data.
- `wo_ready_o`, out, 1: the wo buffer can accept a write.
- `rw_v_i`, in, 1: rw request valid.
- `rw_w_i`, in, 1: 1 = write, 0 = read.
- `rw_addr_i`, in, `bank_addr_width_lp`: rw address.
- `rw_data_i`, in, `data_width_p`: rw write data.
- `rw_yumi_o`, out, 1: rw request consumed this cycle.
- `rw_data_o`, out, `data_width_p`: rw read data.
- `rw_v_o`, out, 1: `rw_data_o` valid. Asserted for reads only.
- `mem_v_o`, out, 1: SRAM enable.
- `mem_w_o`, out, 1: SRAM write enable.
- `mem_addr_o`, out, `bank_addr_width_lp`: SRAM address.
- `mem_data_o`, out, `data_width_p`: SRAM write data.
- `mem_data_i`, in, `data_width_p`: SRAM read data, valid the cycle after a read.

## Operation

**wo buffer**
- FIFO of `{addr, data}` with `wo_fifo_els_p` entries.
- Enqueue occurs on `wo_v_i & wo_ready_o`.
- `wo_ready_o = ~full`. There is no bypass: a dequeue in the same cycle does not make a full FIFO ready.
- An entry becomes eligible for issue the cycle after it is enqueued.

**Grant, evaluated every cycle (combinational)**
1. If `ro_v_i`: ro wins. The SRAM performs a read at `ro_addr_i`. wo and rw are denied. ro may starve the others indefinitely; the ro network is responsible for rate limiting.
2. Otherwise, in mode WO_PRI: the wo FIFO head wins if the FIFO is non-empty, else rw wins if `rw_v_i`.
3. Otherwise, in mode RW_PRI: rw wins if `rw_v_i`, else the wo head wins if the FIFO is non-empty.

**Effect of a grant**
- A wo grant is a write from the FIFO head, which dequeues that entry.
- An rw grant asserts `rw_yumi_o` and issues a read or write per `rw_w_i`.
- `mem_v_o` is 1 exactly when some requester is granted. `mem_addr_o`, `mem_data_o` and `mem_w_o` are muxed from the winner.

**Mode FSM (WO_PRI / RW_PRI)**
- Reset state is WO_PRI.
- The starve counter (width `BSG_SAFE_CLOG2(starve_limit_p+1)`) increments, saturating, on every cycle with `rw_v_i & ~rw_yumi_o`. It clears on `rw_yumi_o` or when `rw_v_i` is low.
- WO_PRI → RW_PRI when the counter reaches `starve_limit_p`.
- RW_PRI → WO_PRI on `rw_yumi_o`, or when `rw_v_i` drops.

**Read return**
- A 2-bit owner register (NONE/RO/RW) is set from the grant: RO for an ro read, RW for an rw read, NONE otherwise.
- The cycle after a read, `ro_v_o = (owner==RO)` and `rw_v_o = (owner==RW)`.
- `ro_data_o = rw_data_o = mem_data_i`, unregistered.

**Ordering and hazards**
- There is no forwarding from the wo FIFO to reads. Ordering between networks is not guaranteed.
- Within one network, program order is preserved.

## Timing

**Reset**
- While `reset_n_i = 0` at a clock edge: the FIFO empties, the counter clears, mode becomes WO_PRI, and owner becomes NONE.
- While `reset_n_i` is low, all grants are forced off. `mem_v_o`, `rw_yumi_o`, `wo_ready_o`, `ro_v_o` and `rw_v_o` are all 0.
- A read issued in the cycle before reset asserts produces no response.

**Latency**
- ro read: request at cycle t, data with `ro_v_o` at t+1.
- rw read: `rw_yumi_o` at t, `rw_v_o` at t+1.
- wo write: accepted at t, reaches the SRAM at t+1 at the earliest.
- Throughput is one SRAM access per cycle.

**rw handshake**
- `rw_v_i` must not depend on `rw_yumi_o`.
- The request must be held stable until `rw_yumi_o`.

**Simultaneous events**
- Enqueue and dequeue in the same cycle on a non-full FIFO leaves the count unchanged.
- ro plus promoted rw in the same cycle: ro wins, and the mode stays RW_PRI.

## Test plan

- **Reset:** `reset_n_i` low for 3 cycles with all `*_v_i = 1` → `mem_v_o`, `rw_yumi_o`, `wo_ready_o`, `ro_v_o` and `rw_v_o` all stay 0. The first cycle after release gives `wo_ready_o = 1` and `mem_v_o = 1` with `addr = ro_addr_i`.
- **ro read:** SRAM word 5 preloaded with 0xA5; `ro_v_i` at t with addr 5 → at t, `mem_v_o = 1`, `mem_w_o = 0`, `mem_addr_o = 5`. At t+1, `ro_v_o = 1` and `ro_data_o = 0xA5`, with `rw_v_o = 0`.
- **wo then rw:** wo write (addr 7, data 0x1234) accepted at t → SRAM write at t+1. An rw read of addr 7 granted at t+2 → `rw_v_o = 1` with `rw_data_o = 0x1234` at t+3.
- **Anti-starvation:** `starve_limit_p = 4`; wo FIFO kept non-empty and `rw_v_i` held high → `rw_yumi_o` in the 5th cycle of the request, followed by a return to WO_PRI with the wo head granted the next cycle.
- **Back-pressure:** `wo_fifo_els_p = 2`, `ro_v_i` held high, 3 wo writes offered → `wo_ready_o = 0` after 2 accepts. After `ro_v_i` drops, the 2 writes drain in 2 consecutive cycles and the 3rd write is accepted.
- **Reset mid-operation:** rw read granted at t, reset low at t+1 → `rw_v_o = 0` at t+1. After release, the FIFO is empty and the mode is WO_PRI.

Source files
------------

// File: rtl/bsg_global_buffer_bank_arbiter.sv
// rtl/bsg_global_buffer_bank_arbiter.sv - shares one 1RW bank between ro, wo and rw requesters
// ro has absolute priority; wo/rw alternate priority via a starvation-driven mode register.
module bsg_global_buffer_bank_arbiter #(
  parameter int data_width_p   = 32,
  parameter int bank_els_p     = 1024,
  parameter int wo_fifo_els_p  = 2,
  parameter int starve_limit_p = 4,
  localparam int bank_addr_width_lp = (bank_els_p > 1) ? $clog2(bank_els_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          ro_v_i,
  input  logic [bank_addr_width_lp-1:0] ro_addr_i,
  output logic [data_width_p-1:0]       ro_data_o,
  output logic                          ro_v_o,
  input  logic                          wo_v_i,
  input  logic [bank_addr_width_lp-1:0] wo_addr_i,
  input  logic [data_width_p-1:0]       wo_data_i,
  output logic                          wo_ready_o,
  input  logic                          rw_v_i,
  input  logic                          rw_w_i,
  input  logic [bank_addr_width_lp-1:0] rw_addr_i,
  input  logic [data_width_p-1:0]       rw_data_i,
  output logic                          rw_yumi_o,
  output logic [data_width_p-1:0]       rw_data_o,
  output logic                          rw_v_o,
  output logic                          mem_v_o,
  output logic                          mem_w_o,
  output logic [bank_addr_width_lp-1:0] mem_addr_o,
  output logic [data_width_p-1:0]       mem_data_o,
  input  logic [data_width_p-1:0]       mem_data_i
);

  localparam int ptr_w_lp    = (wo_fifo_els_p > 1) ? $clog2(wo_fifo_els_p) : 1;
  localparam int cnt_w_lp    = $clog2(wo_fifo_els_p + 1);
  localparam int starve_w_lp = $clog2(starve_limit_p + 1);

  typedef enum logic {e_wo_pri, e_rw_pri} mode_e;
  typedef enum logic [1:0] {e_own_none, e_own_ro, e_own_rw} owner_e;

  mode_e                   mode_q, mode_d;
  owner_e                  owner_q, owner_d;
  logic [starve_w_lp-1:0]  starve_q, starve_d;
  logic [cnt_w_lp-1:0]     count_q, count_d;
  logic [ptr_w_lp-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  logic [bank_addr_width_lp-1:0] fifo_addr_q [wo_fifo_els_p];
  logic [data_width_p-1:0]       fifo_data_q [wo_fifo_els_p];

  logic empty, full, enq, ro_gnt, wo_gnt, rw_gnt;

  assign empty      = (count_q == '0);
  assign full       = (count_q == cnt_w_lp'(wo_fifo_els_p));
  assign wo_ready_o = reset_n_i & ~full;
  assign enq        = wo_v_i & wo_ready_o;

  always_comb begin
    ro_gnt = 1'b0;
    wo_gnt = 1'b0;
    rw_gnt = 1'b0;
    if (reset_n_i) begin
      if (ro_v_i) begin
        ro_gnt = 1'b1;
      end else if (mode_q == e_rw_pri) begin
        rw_gnt = rw_v_i;
        wo_gnt = ~rw_v_i & ~empty;
      end else begin
        wo_gnt = ~empty;
        rw_gnt = empty & rw_v_i;
      end
    end
  end

  assign rw_yumi_o  = rw_gnt;
  assign mem_v_o    = ro_gnt | wo_gnt | rw_gnt;
  assign mem_w_o    = wo_gnt | (rw_gnt & rw_w_i);
  assign mem_addr_o = ro_gnt ? ro_addr_i : (wo_gnt ? fifo_addr_q[rd_ptr_q] : rw_addr_i);
  assign mem_data_o = wo_gnt ? fifo_data_q[rd_ptr_q] : rw_data_i;

  // Read data is not registered here; only its destination is tracked.
  assign ro_v_o    = reset_n_i & (owner_q == e_own_ro);
  assign rw_v_o    = reset_n_i & (owner_q == e_own_rw);
  assign ro_data_o = mem_data_i;
  assign rw_data_o = mem_data_i;

  always_comb begin
    starve_d = '0;
    if (rw_v_i & ~rw_gnt)
      starve_d = (starve_q == starve_w_lp'(starve_limit_p)) ? starve_q : starve_q + 1'b1;

    mode_d = mode_q;
    if (mode_q == e_wo_pri) begin
      if (starve_d == starve_w_lp'(starve_limit_p)) mode_d = e_rw_pri;
    end else if (rw_gnt | ~rw_v_i) begin
      mode_d = e_wo_pri;
    end

    owner_d = e_own_none;
    if (ro_gnt) owner_d = e_own_ro;
    else if (rw_gnt & ~rw_w_i) owner_d = e_own_rw;

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (enq & ~wo_gnt) count_d = count_q + 1'b1;
    if (~enq & wo_gnt) count_d = count_q - 1'b1;
    if (enq)
      wr_ptr_d = (wr_ptr_q == ptr_w_lp'(wo_fifo_els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (wo_gnt)
      rd_ptr_d = (rd_ptr_q == ptr_w_lp'(wo_fifo_els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mode_q   <= e_wo_pri;
      owner_q  <= e_own_none;
      starve_q <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      mode_q   <= mode_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_addr_q[wr_ptr_q] <= wo_addr_i;
      fifo_data_q[wr_ptr_q] <= wo_data_i;
    end
  end

endmodule

// File: tb/tb_bsg_global_buffer_bank_arbiter.sv
// tb/tb_bsg_global_buffer_bank_arbiter.sv - random stimulus against a queue-based bank arbiter model
module tb_bsg_global_buffer_bank_arbiter;

  localparam int dw = 32;
  localparam int aw = 10;
  localparam int els = 1024;
  localparam int fifo_els = 2;
  localparam int starve_lim = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n_i;
  logic          ro_v_i, wo_v_i, rw_v_i, rw_w_i;
  logic [aw-1:0] ro_addr_i, wo_addr_i, rw_addr_i;
  logic [dw-1:0] wo_data_i, rw_data_i;
  logic [dw-1:0] ro_data_o, rw_data_o, mem_data_o, mem_data_i;
  logic          ro_v_o, wo_ready_o, rw_yumi_o, rw_v_o, mem_v_o, mem_w_o;
  logic [aw-1:0] mem_addr_o;

  bsg_global_buffer_bank_arbiter #(
    .data_width_p(dw), .bank_els_p(els), .wo_fifo_els_p(fifo_els), .starve_limit_p(starve_lim)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .ro_v_i(ro_v_i), .ro_addr_i(ro_addr_i), .ro_data_o(ro_data_o), .ro_v_o(ro_v_o),
    .wo_v_i(wo_v_i), .wo_addr_i(wo_addr_i), .wo_data_i(wo_data_i), .wo_ready_o(wo_ready_o),
    .rw_v_i(rw_v_i), .rw_w_i(rw_w_i), .rw_addr_i(rw_addr_i), .rw_data_i(rw_data_i),
    .rw_yumi_o(rw_yumi_o), .rw_data_o(rw_data_o), .rw_v_o(rw_v_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  // Bank SRAM, driven only by the DUT's memory port.
  logic [dw-1:0] sram [els];
  logic [dw-1:0] sram_rdata_q = '0;
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
      else         sram_rdata_q <= sram[mem_addr_o];
    end
  end
  assign mem_data_i = sram_rdata_q;

  // Reference: shadow memory contents, pending wo writes, starvation bookkeeping.
  typedef struct packed { logic [aw-1:0] a; logic [dw-1:0] d; } wo_t;
  logic [dw-1:0] shadow [els];
  wo_t           woq[$];
  int            starved;
  bit            promoted;
  int            pend;       // 0 none, 1 ro, 2 rw
  logic [dw-1:0] pend_data;
  bit            rw_taken;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called with inputs already driven at the falling edge.
  task automatic step();
    int  w;
    bit  exp_ready, exp_w;
    logic [aw-1:0] exp_a;
    logic [dw-1:0] exp_d;
    #1;
    rw_taken = 1'b0;
    if (!reset_n_i) begin
      check_eq("rst_mem_v", 64'(mem_v_o), 64'd0);
      check_eq("rst_yumi", 64'(rw_yumi_o), 64'd0);
      check_eq("rst_ready", 64'(wo_ready_o), 64'd0);
      check_eq("rst_ro_v", 64'(ro_v_o), 64'd0);
      check_eq("rst_rw_v", 64'(rw_v_o), 64'd0);
      woq.delete();
      starved = 0;
      promoted = 1'b0;
      pend = 0;
    end else begin
      exp_ready = (woq.size() < fifo_els);
      check_eq("wo_ready", 64'(wo_ready_o), 64'(exp_ready));
      check_eq("ro_v_o", 64'(ro_v_o), 64'(pend == 1));
      check_eq("rw_v_o", 64'(rw_v_o), 64'(pend == 2));
      if (pend == 1) check_eq("ro_data", 64'(ro_data_o), 64'(pend_data));
      if (pend == 2) check_eq("rw_data", 64'(rw_data_o), 64'(pend_data));

      if (ro_v_i)        w = 1;
      else if (promoted) w = rw_v_i ? 3 : (woq.size() > 0 ? 2 : 0);
      else               w = (woq.size() > 0) ? 2 : (rw_v_i ? 3 : 0);

      exp_a = (w == 1) ? ro_addr_i : (w == 2) ? woq[0].a : rw_addr_i;
      exp_d = (w == 2) ? woq[0].d : rw_data_i;
      exp_w = (w == 2) || (w == 3 && rw_w_i);
      check_eq("mem_v", 64'(mem_v_o), 64'(w != 0));
      check_eq("rw_yumi", 64'(rw_yumi_o), 64'(w == 3));
      if (w != 0) begin
        check_eq("mem_w", 64'(mem_w_o), 64'(exp_w));
        check_eq("mem_addr", 64'(mem_addr_o), 64'(exp_a));
        if (exp_w) check_eq("mem_data", 64'(mem_data_o), 64'(exp_d));
      end

      pend = 0;
      if (w != 0 && !exp_w) begin
        pend = (w == 1) ? 1 : 2;
        pend_data = shadow[exp_a];
      end
      if (exp_w) shadow[exp_a] = exp_d;
      if (w == 2) void'(woq.pop_front());
      if (wo_v_i && exp_ready) woq.push_back({wo_addr_i, wo_data_i});

      if (rw_v_i && w != 3) starved = (starved < starve_lim) ? starved + 1 : starved;
      else                  starved = 0;
      if (promoted) begin
        if (w == 3 || !rw_v_i) promoted = 1'b0;
      end else if (starved == starve_lim) begin
        promoted = 1'b1;
      end
      if (w == 3) rw_taken = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drive(input int ro_pct, input int wo_pct, input int rw_pct, input int rst_pct);
    reset_n_i = ($urandom_range(0, 99) >= rst_pct);
    ro_v_i    = ($urandom_range(0, 99) < ro_pct);
    ro_addr_i = aw'($urandom_range(0, 15));
    wo_v_i    = ($urandom_range(0, 99) < wo_pct);
    wo_addr_i = aw'($urandom_range(0, 15));
    wo_data_i = $urandom;
    if (rw_taken) rw_v_i = 1'b0;
    if (!rw_v_i && $urandom_range(0, 99) < rw_pct) begin
      rw_v_i    = 1'b1;
      rw_w_i    = 1'($urandom_range(0, 1));
      rw_addr_i = aw'($urandom_range(0, 15));
      rw_data_i = $urandom;
    end
  endtask

  initial begin
    for (int i = 0; i < els; i++) begin
      sram[i]   = dw'(i * 32'h0101_0007);
      shadow[i] = dw'(i * 32'h0101_0007);
    end
    sram[5]   = 32'hA5;
    shadow[5] = 32'hA5;
    woq.delete();
    starved = 0; promoted = 1'b0; pend = 0; pend_data = '0; rw_taken = 1'b0;
    reset_n_i = 1'b0;
    ro_v_i = 1'b1; ro_addr_i = 10'd5;
    wo_v_i = 1'b1; wo_addr_i = 10'd7; wo_data_i = 32'h1234;
    rw_v_i = 1'b1; rw_w_i = 1'b0; rw_addr_i = 10'd7; rw_data_i = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();

    // Release with every requester active: ro read of word 5 wins first.
    reset_n_i = 1'b1;
    step();
    ro_v_i = 1'b0; wo_v_i = 1'b0;
    if (rw_taken) rw_v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rw_taken) rw_v_i = 1'b0;
    end

    // Sustained wo traffic against a held rw request exercises promotion.
    for (int i = 0; i < 60; i++) begin
      drive(0, 100, 100, 0);
      step();
    end
    // ro-heavy traffic fills the wo buffer and starves rw.
    for (int i = 0; i < 800; i++) begin
      drive(80, 70, 60, 0);
      step();
    end
    for (int i = 0; i < 800; i++) begin
      drive(30, 50, 50, 0);
      step();
    end
    for (int i = 0; i < 1500; i++) begin
      drive(40, 60, 60, 4);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
